// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory boot loader.
package imem_loader_pkg;
   typedef enum logic [2:0] {
      HDR,
      DATA,
      CSUM,
      LOAD_DONE,
      LOAD_ERR
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_W         = 8;
   localparam int FIELD_W        = BYTE_W * BYTES_PER_WORD;
   localparam int IDX_W          = $clog2(BYTES_PER_WORD);
endpackage

// File: rtl/imem_loader_byte_to_word.sv
// Little-endian byte-to-word assembler shared by the header, payload and checksum fields.
module byte_to_word
   import imem_loader_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               byte_en,
   input  logic [BYTE_W-1:0]  byte_data,
   output logic [FIELD_W-1:0] word,
   output logic               word_valid
);
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [FIELD_W-1:0] shreg_q, shreg_d;

   // word carries the byte being accepted now, so it is complete on the cycle word_valid is high
   always_comb begin
      word = shreg_q;
      word[{idx_q, 3'b000} +: BYTE_W] = byte_data;
   end

   assign word_valid = byte_en && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

   always_comb begin
      idx_d   = idx_q;
      shreg_d = shreg_q;
      if (clr) begin
         idx_d   = '0;
         shreg_d = '0;
      end else if (byte_en) begin
         idx_d   = idx_q + IDX_W'(1);
         shreg_d = word_valid ? '0 : word;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q   <= '0;
         shreg_q <= '0;
      end else begin
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
      end
   end
endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length/payload/checksum byte frame into instruction RAM writes
// and keeps the core in reset until the image checksum has verified.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 13,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                byte_valid,
   input  logic [7:0]          byte_data,
   output logic                byte_ready,
   input  logic                reload,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [31:0]         mem_wdata,
   output logic                cpu_hold,
   output logic                done,
   output logic                error,
   output logic [ADDR_W:0]     words_written
);
   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     rem_q, rem_d;
   logic [ADDR_W:0]     words_q, words_d;
   logic [FIELD_W-1:0]  csum_q, csum_d;
   logic [FIELD_W-1:0]  wdata_q, wdata_d;
   logic                we_q, we_d;

   logic                byte_en;
   logic                field_clr;
   logic [FIELD_W-1:0]  word;
   logic                word_valid;

   assign byte_ready = !rst && (state_q == HDR || state_q == DATA || state_q == CSUM);
   assign byte_en    = byte_valid && byte_ready;

   byte_to_word u_b2w (
      .clk        (clk),
      .rst        (rst),
      .clr        (field_clr),
      .byte_en    (byte_en),
      .byte_data  (byte_data),
      .word       (word),
      .word_valid (word_valid)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      words_d   = words_q;
      csum_d    = csum_q;
      wdata_d   = wdata_q;
      we_d      = 1'b0;
      field_clr = 1'b0;

      // The last payload write happens after the move to CSUM, so the address stops at DEPTH-1
      if (we_q && state_q == DATA) addr_d = addr_q + ADDR_W'(1);

      case (state_q)
         HDR: if (word_valid) begin
            if (word > 32'(DEPTH)) begin
               state_d = LOAD_ERR;
            end else if (word == 0) begin
               state_d = CSUM;
            end else begin
               state_d = DATA;
               rem_d   = word[ADDR_W:0];
               addr_d  = '0;
            end
         end
         DATA: if (word_valid) begin
            we_d    = 1'b1;
            wdata_d = word;
            csum_d  = csum_q ^ word;
            words_d = words_q + (ADDR_W+1)'(1);
            rem_d   = rem_q - (ADDR_W+1)'(1);
            if (rem_q == (ADDR_W+1)'(1)) state_d = CSUM;
         end
         CSUM: if (word_valid) begin
            state_d = (word == csum_q) ? LOAD_DONE : LOAD_ERR;
         end
         LOAD_DONE, LOAD_ERR: if (reload) begin
            state_d   = HDR;
            addr_d    = '0;
            rem_d     = '0;
            words_d   = '0;
            csum_d    = '0;
            field_clr = 1'b1;
         end
         default: state_d = HDR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= HDR;
         addr_q  <= '0;
         rem_q   <= '0;
         words_q <= '0;
         csum_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         words_q <= words_d;
         csum_q  <= csum_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
      end
   end

   assign mem_we        = we_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign words_written = words_q;
   assign done          = (state_q == LOAD_DONE);
   assign error         = (state_q == LOAD_ERR);
   assign cpu_hold      = (state_q != LOAD_DONE);
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed images, checksum/length errors, gaps, reset and max size.
module tb_imem_loader;
   localparam int ADDR_W = 13;
   localparam int DEPTH  = 2**ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              byte_valid = 1'b0;
   logic [7:0]        byte_data = 8'h00;
   logic              byte_ready;
   logic              reload = 1'b0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_written;

   int tests = 0;
   int fails = 0;
   int stall_cnt = 0;
   logic [ADDR_W-1:0] wr_addr[$];
   logic [31:0]       wr_data[$];

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_ready    (byte_ready),
      .reload        (reload),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .cpu_hold      (cpu_hold),
      .done          (done),
      .error         (error),
      .words_written (words_written)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_wdata);
         $display("[TB] write addr=%h data=%h", mem_addr, mem_wdata);
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] pat(input int kind, input int i);
      if (kind == 0) return (i == 0) ? 32'h0000_0013 : 32'h00A0_0093;
      return (32'(i) * 32'h9E37_79B1) ^ (32'(kind) << 24) ^ 32'h0000_5A5A;
   endfunction

   function automatic logic [31:0] xsum(input int kind, input int n);
      logic [31:0] c = '0;
      for (int i = 0; i < n; i++) c ^= pat(kind, i);
      return c;
   endfunction

   // Called at a negedge; returns at the negedge after the byte was transferred.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n = 0;
      if (gaps) begin
         while ($urandom_range(0, 1) == 0) begin
            byte_valid = 1'b0;
            @(negedge clk);
            if (!byte_ready) stall_cnt++;
         end
      end
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) begin
         tests++; fails++;
         $display("FAIL send_byte timeout: byte_ready=%b required 1", byte_ready);
         byte_valid = 1'b0;
         return;
      end
      if (n != 0) stall_cnt++;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      logic [31:0] v = w;
      for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8], gaps);
   endtask

   task automatic send_image(input int n, input int kind, input logic [31:0] c, input bit gaps);
      send_word(32'(n), gaps);
      for (int i = 0; i < n; i++) send_word(pat(kind, i), gaps);
      send_word(c, gaps);
   endtask

   task automatic rearm();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      tests++;
      if ({byte_ready, cpu_hold, done, error, mem_we} !== 5'b01000 || mem_addr !== '0 ||
          mem_wdata !== '0 || words_written !== '0) begin
         fails++;
         $display("FAIL reset_values: rdy/hold/done/err/we=%b addr=%h wdata=%h ww=%0d required 01000/0/0/0",
                  {byte_ready, cpu_hold, done, error, mem_we}, mem_addr, mem_wdata, words_written);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests++;
      if (byte_ready !== 1'b1) begin
         fails++; $display("FAIL reset_ready_hdr: byte_ready=%b required 1", byte_ready);
      end
      @(negedge clk);
      $display("[TB] test_reset complete");
   endtask

   task automatic test_basic();
      logic [31:0] c = 32'h00A0_0080;
      send_word(32'd2, 1'b0);
      send_word(32'h0000_0013, 1'b0);
      tests++;
      if (mem_we !== 1'b1 || mem_addr !== 13'h0 || mem_wdata !== 32'h0000_0013 || words_written !== 14'd1) begin
         fails++;
         $display("FAIL basic_write0: we=%b addr=%h data=%h ww=%0d required 1/0000/00000013/1",
                  mem_we, mem_addr, mem_wdata, words_written);
      end
      send_word(32'h00A0_0093, 1'b0);
      tests++;
      if (mem_we !== 1'b1 || mem_addr !== 13'h1 || mem_wdata !== 32'h00A0_0093 || words_written !== 14'd2) begin
         fails++;
         $display("FAIL basic_write1: we=%b addr=%h data=%h ww=%0d required 1/0001/00a00093/2",
                  mem_we, mem_addr, mem_wdata, words_written);
      end
      for (int k = 0; k < 3; k++) send_byte(c[8*k +: 8], 1'b0);
      tests++;
      if (done !== 1'b0 || cpu_hold !== 1'b1) begin
         fails++; $display("FAIL basic_early_done: done=%b hold=%b required 0/1", done, cpu_hold);
      end
      send_byte(c[31:24], 1'b0);
      tests++;
      if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0 || words_written !== 14'd2 || byte_ready !== 1'b0) begin
         fails++;
         $display("FAIL basic_done: done=%b hold=%b err=%b ww=%0d rdy=%b required 1/0/0/2/0",
                  done, cpu_hold, error, words_written, byte_ready);
      end
      $display("[TB] test_basic complete");
   endtask

   task automatic test_bad_checksum();
      rearm();
      send_image(2, 0, 32'h0, 1'b0);
      tests++;
      if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || byte_ready !== 1'b0) begin
         fails++;
         $display("FAIL csum_error: err=%b done=%b hold=%b rdy=%b required 1/0/1/0", error, done, cpu_hold, byte_ready);
      end
      rearm();
      tests++;
      if (error !== 1'b0 || cpu_hold !== 1'b1 || words_written !== '0 || mem_addr !== '0 || byte_ready !== 1'b1) begin
         fails++;
         $display("FAIL reload_clear: err=%b hold=%b ww=%0d addr=%h rdy=%b required 0/1/0/0/1",
                  error, cpu_hold, words_written, mem_addr, byte_ready);
      end
      send_image(2, 0, 32'h00A0_0080, 1'b0);
      tests++;
      if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
         fails++; $display("FAIL reload_done: done=%b err=%b hold=%b required 1/0/0", done, error, cpu_hold);
      end
      $display("[TB] test_bad_checksum complete");
   endtask

   task automatic test_length();
      rearm();
      wr_addr.delete(); wr_data.delete();
      send_word(32'h0000_2001, 1'b0);
      tests++;
      if (error !== 1'b1 || byte_ready !== 1'b0 || cpu_hold !== 1'b1) begin
         fails++; $display("FAIL len_too_big: err=%b rdy=%b hold=%b required 1/0/1", error, byte_ready, cpu_hold);
      end
      repeat (3) @(negedge clk);
      tests++;
      if (wr_addr.size() != 0) begin
         fails++; $display("FAIL len_no_write: writes=%0d required 0", wr_addr.size());
      end
      rearm();
      send_word(32'h0, 1'b0);
      send_word(32'h0, 1'b0);
      tests++;
      if (done !== 1'b1 || error !== 1'b0 || wr_addr.size() != 0 || words_written !== '0) begin
         fails++;
         $display("FAIL len_zero: done=%b err=%b writes=%0d ww=%0d required 1/0/0/0",
                  done, error, wr_addr.size(), words_written);
      end
      $display("[TB] test_length complete");
   endtask

   task automatic test_gaps();
      logic [31:0] ref_d[$];
      int bad = 0;
      rearm();
      wr_addr.delete(); wr_data.delete();
      send_image(16, 2, xsum(2, 16), 1'b0);
      ref_d = wr_data;
      rearm();
      wr_addr.delete(); wr_data.delete();
      stall_cnt = 0;
      send_image(16, 2, xsum(2, 16), 1'b1);
      tests++;
      if (done !== 1'b1 || stall_cnt != 0) begin
         fails++; $display("FAIL gaps_done: done=%b stalls=%0d required 1/0", done, stall_cnt);
      end
      tests++;
      if (wr_addr.size() != 16 || ref_d.size() != 16) begin
         fails++; $display("FAIL gaps_count: writes=%0d ref=%0d required 16/16", wr_addr.size(), ref_d.size());
      end else begin
         for (int i = 0; i < 16; i++)
            if (wr_addr[i] !== 13'(i) || wr_data[i] !== pat(2, i) || ref_d[i] !== wr_data[i]) bad++;
         if (bad != 0) begin
            fails++; $display("FAIL gaps_data: %0d bad writes required 0", bad);
         end
      end
      $display("[TB] test_gaps complete");
   endtask

   task automatic test_mid_reset();
      logic [31:0] w1 = pat(3, 1);
      int bad = 0;
      rearm();
      wr_addr.delete(); wr_data.delete();
      send_word(32'd4, 1'b0);
      send_word(pat(3, 0), 1'b0);
      send_byte(w1[7:0], 1'b0);
      send_byte(w1[15:8], 1'b0);
      tests++;
      if (words_written !== 14'd1 || mem_addr !== 13'h1) begin
         fails++; $display("FAIL pre_reset: ww=%0d addr=%h required 1/0001", words_written, mem_addr);
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({byte_ready, cpu_hold, done, error, mem_we} !== 5'b01000 || mem_addr !== '0 ||
          mem_wdata !== '0 || words_written !== '0) begin
         fails++;
         $display("FAIL async_reset: rdy/hold/done/err/we=%b addr=%h wdata=%h ww=%0d required 01000/0/0/0",
                  {byte_ready, cpu_hold, done, error, mem_we}, mem_addr, mem_wdata, words_written);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      wr_addr.delete(); wr_data.delete();
      send_image(4, 3, xsum(3, 4), 1'b0);
      tests++;
      if (done !== 1'b1 || wr_addr.size() != 4) begin
         fails++; $display("FAIL reset_reload: done=%b writes=%0d required 1/4", done, wr_addr.size());
      end else begin
         for (int i = 0; i < 4; i++) if (wr_addr[i] !== 13'(i) || wr_data[i] !== pat(3, i)) bad++;
         if (bad != 0) begin
            fails++; $display("FAIL reset_reload_data: %0d bad writes required 0", bad);
         end
      end
      $display("[TB] test_mid_reset complete");
   endtask

   task automatic test_max_image();
      int bad = 0;
      int nw;
      rearm();
      wr_addr.delete(); wr_data.delete();
      send_image(DEPTH, 4, xsum(4, DEPTH), 1'b0);
      tests++;
      if (done !== 1'b1 || words_written !== 14'd8192 || mem_addr !== 13'h1FFF || cpu_hold !== 1'b0) begin
         fails++;
         $display("FAIL max_done: done=%b ww=%0d addr=%h hold=%b required 1/8192/1fff/0",
                  done, words_written, mem_addr, cpu_hold);
      end
      tests++;
      if (wr_addr.size() != DEPTH) begin
         fails++; $display("FAIL max_count: writes=%0d required %0d", wr_addr.size(), DEPTH);
      end else begin
         for (int i = 0; i < DEPTH; i++) if (wr_addr[i] !== 13'(i) || wr_data[i] !== pat(4, i)) bad++;
         if (bad != 0 || wr_addr[DEPTH-1] !== 13'h1FFF) begin
            fails++; $display("FAIL max_data: %0d bad writes, last addr=%h required 0/1fff", bad, wr_addr[DEPTH-1]);
         end
      end
      nw = wr_addr.size();
      for (int k = 0; k < 8; k++) begin
         byte_valid = 1'b1;
         byte_data  = 8'(8'hC0 + k);
         @(negedge clk);
      end
      byte_valid = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (wr_addr.size() != nw || done !== 1'b1 || byte_ready !== 1'b0) begin
         fails++;
         $display("FAIL after_done: new writes=%0d done=%b rdy=%b required 0/1/0", wr_addr.size() - nw, done, byte_ready);
      end
      $display("[TB] test_max_image complete");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_checksum();
      test_length();
      test_gaps();
      test_mid_reset();
      test_max_image();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory: receives a framed byte stream (header, payload, checksum) and writes 32-bit words into the instruction RAM's write port.
- Holds the CPU core in reset until a valid image has been fully loaded and its checksum verified.
- Sits between a byte source (UART receiver or testbench) and port B of the instruction memory. The core fetches from port A.

Parameters:
- ADDR_W, 13, word-address width of the instruction memory. Matches the core's fetch address bits pc[14:2].
- DEPTH, 2**ADDR_W, maximum number of loadable words.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- byte_valid  in  1  source presents byte_data
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle; transfer occurs when byte_valid && byte_ready
- reload  in  1  single-cycle pulse; re-arms the loader from LOAD_DONE or LOAD_ERR
- mem_we  out  1  instruction memory write enable, one-cycle pulse
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  word to write
- cpu_hold  out  1  active-high reset to the core
- done  out  1  image loaded and verified
- error  out  1  length or checksum failure
- words_written  out  ADDR_W+1  count of words written in the current load

Behaviour:
- Reset values (asynchronous):
  - state=HDR, byte_ready=0 during rst then 1 in HDR
  - cpu_hold=1, done=0, error=0
  - mem_we=0, mem_addr=0, mem_wdata=0, words_written=0
  - byte index=0, checksum accumulator=0
- Frame format, all fields little-endian:
  - 4-byte word count N
  - N payload words (4 bytes each)
  - 4-byte checksum C, where C = XOR of all payload words (0 when N=0)
- Byte assembly: byte k of a field lands in bits [8k+7:8k]. A 2-bit byte index wraps 3->0 on each completed field.
- States and transitions:
  - HDR: byte_ready=1; assemble N.
    - On the 4th byte: N > DEPTH -> ERR.
    - N == 0 -> CSUM.
    - Else -> DATA with remaining=N, mem_addr=0.
  - DATA: byte_ready=1; assemble a word.
    - On its 4th byte, in the next cycle: mem_we=1, mem_wdata=word, mem_addr=current address.
    - Also in that cycle: checksum ^= word, words_written++.
    - Address increments after the write.
    - After the Nth word -> CSUM. byte_ready stays high, so back-to-back bytes never stall and the write overlaps the next field's first byte.
  - CSUM: byte_ready=1; assemble C.
    - On the 4th byte: C == accumulator -> DONE, else -> ERR.
    - The comparison includes the write pending from the last payload word.
  - DONE: byte_ready=0, done=1, cpu_hold=0. Incoming bytes are ignored.
  - ERR: byte_ready=0, error=1, cpu_hold=1. Memory contents are undefined.
- reload:
  - In DONE or ERR: return to HDR next cycle.
  - On return: cpu_hold=1, done=0, error=0, words_written=0, accumulator=0, byte index=0, mem_addr=0.
  - In HDR/DATA/CSUM: ignored.
- Boundaries:
  - N == DEPTH is accepted. The last word goes to address DEPTH-1 and the address does not wrap before CSUM.
  - byte_valid low mid-field: the partial field is held indefinitely (no timeout).
  - rst mid-load: immediate return to reset values. A partial image stays in RAM but cpu_hold remains 1.
  - cpu_hold never drops before done=1.
- Latency: the write pulse comes 1 cycle after the word's last byte is accepted. done/error assert 1 cycle after the last checksum byte.

Decomposition:
- Shared package `imem_loader_pkg`:
  - state enum (HDR, DATA, CSUM, LOAD_DONE, LOAD_ERR)
  - BYTES_PER_WORD=4
  - frame field widths
- One natural sub-module, `byte_to_word`:
  - 2-bit index plus 32-bit shift/insert register
  - outputs word and word_valid
  - cleared by state-machine field boundaries
  - instantiated once and reused across the header, payload and checksum fields

Test Plan:
1. Stream N=2, words 0x00000013 and 0x00A00093, C=0x00A00080, one byte/cycle -> mem_we at addr 0 then addr 1 with those data; done=1 and cpu_hold=0 one cycle after the last byte; words_written=2.
2. Same image with C=0x00000000 -> error=1, done=0, cpu_hold stays 1, byte_ready=0; then pulse reload and resend the correct image -> done=1.
3. N=0x00002001 (DEPTH+1) -> error=1 right after the 4th header byte, no mem_we ever; N=0 with C=0 -> done=1, no writes.
4. Random byte_valid gaps (50% duty) on a 16-word image -> writes identical to the gap-free run, no dropped or duplicated bytes, byte_ready never low before DONE.
5. Assert rst after the 6th payload byte -> all outputs return to reset values asynchronously; a fresh full image then loads correctly from addr 0.
6. N=DEPTH max image -> final write at addr 0x1FFF, words_written=8192, done=1; bytes sent after done are ignored and produce no mem_we.
